mult35_stream: RTL and testbench
================================

Name: mult35_stream

Overview:
- Producer-side companion to the multiples-of-3-and-5 accumulator.
- The accumulator consumes N and returns one sum. This block takes N and transmits every multiple of 3 or 5 in [1, N-1], in ascending order, one term per valid/ready beat, each with a divisibility tag.
- It also keeps a running sum as a cross-check against the accumulator's result.
- It sits between the start/busy control interface and any downstream consumer: FIFO, display driver or checker.

Parameters:
- W, 16, width of N and of each emitted term.
- SW, 32, width of the running sum. 32 covers the worst case for W=16, about 1.0e9.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- in  input  W  upper bound N, exclusive; sampled on accepted st.
- st  input  1  start request; sampled only in IDLE.
- busy  output  1  high from the cycle after st is accepted until the cycle after done.
- out  output  W  current term; stable while valid && !ready.
- tag  output  2  tag[0]=term divisible by 3, tag[1]=term divisible by 5.
- valid  output  1  term present on out/tag.
- ready  input  1  consumer accepts when valid && ready at a rising edge.
- sum  output  SW  running sum of emitted terms; holds final value after done until next accepted st.
- done  output  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset (rst_n=0, async): state IDLE; busy=0, valid=0, done=0, out=0, tag=0, sum=0; internal k=0, m3=0, m5=0. Reset mid-run aborts immediately; no partial beat is held.
- No dividers. m3 counts 0..2 and wraps 2->0; m5 counts 0..4 and wraps 4->0. Both track k mod 3 and k mod 5 and increment together with k.
- IDLE:
  - st=1: latch Nreg=in, k=1, m3=1, m5=1, sum=0; go to SCAN; busy=1 next cycle.
  - st=0: stay.
- SCAN, one candidate k per cycle:
  - k >= Nreg: go to FIN.
  - m3==0 or m5==0: load out=k, tag={m5==0, m3==0}; valid=1; sum += k (in the same edge as the load); go to HOLD.
  - Otherwise: k, m3 and m5 increment; stay in SCAN.
- HOLD:
  - valid stays 1; out and tag are frozen.
  - On valid && ready: valid=0 next cycle; k, m3 and m5 increment; go to SCAN.
  - ready=0: wait indefinitely.
- FIN: done=1 for exactly one cycle, then IDLE. busy=0 in IDLE; sum holds.
- st asserted while busy is ignored; no queuing.
- N <= 3: zero beats. Sequence is st -> SCAN (k=1..N, or immediate FIN) -> done; sum=0.
- N=0: immediate FIN on the first SCAN cycle.
- k never exceeds Nreg, so k cannot overflow W bits for any N up to 2^W-1.
- No combinational path from ready to valid/out. Outputs are registered.
- Beat order is strictly ascending; 15k terms are emitted once, with tag=2'b11.

Optional Feature:
- MULT35_WHEEL_EN defined:
  - SCAN uses a 15-entry wheel indexed by k mod 15 (from m3/m5) to jump k straight to the next multiple in one cycle.
  - HOLD advances directly to the next multiple on handshake. With ready held high, beats are issued every cycle: valid stays 1 across consecutive beats and SCAN is bypassed.
  - FIN is entered when the next multiple >= Nreg.
- Undefined: one candidate per cycle, as described above.
- Data, tags, sum, done and reset behaviour are identical in both builds; only cycle counts differ.

Test Plan:
- N=10, ready=1 -> out 3,5,6,9 with tags 01,10,01,01; sum=23; single done pulse; busy drops after done.
- N=16 -> 3,5,6,9,10,12,15; tag for 15 = 11; sum=60.
- N=3, then N=0 -> no valid beats; done pulses once each; sum=0.
- N=1000 with ready toggled pseudo-randomly -> 466 beats, strictly ascending; sum=233168; out/tag stable whenever valid && !ready.
- st pulsed again mid-run with in=50 -> ignored, original N=20 sequence completes, sum=78; rst_n pulsed low during HOLD -> valid, busy and sum clear at once, block returns to IDLE.
- MULT35_WHEEL_EN build, N=16, ready=1 -> 7 beats on 7 consecutive cycles after the first; results match the default build.

Source files
------------

// File: rtl/mult35_if.sv
// Stream bus for mult35_stream: start/busy control on one side,
// valid/ready term stream plus running sum and done pulse on the other.
interface mult35_if #(
  parameter int W  = 16,
  parameter int SW = 32
);
  logic [W-1:0]  in;
  logic          st;
  logic          busy;
  logic [W-1:0]  out;
  logic [1:0]    tag;
  logic          valid;
  logic          ready;
  logic [SW-1:0] sum;
  logic          done;

  modport master (output in, st, ready, input busy, out, tag, valid, sum, done);
  modport slave  (input in, st, ready, output busy, out, tag, valid, sum, done);
endinterface

// File: rtl/mult35_stream.sv
// mult35_stream: emits every multiple of 3 or 5 in [1, N-1] in ascending
// order, one term per valid/ready beat, with a divisibility tag and a
// running sum. Residues mod 3 / mod 5 are tracked by wrap counters, so no
// divider is needed.
// Optional build macro MULT35_WHEEL_EN: a 15-entry wheel jumps k straight
// to the next multiple, giving back-to-back beats while ready stays high.
module mult35_stream #(
  parameter int W  = 16,
  parameter int SW = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mult35_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SCAN, HOLD, FIN} state_t;

  state_t        state_q;
  logic [W-1:0]  n_q, k_q, out_q;
  logic [1:0]    m3_q, tag_q;
  logic [2:0]    m5_q;
  logic          valid_q, busy_q, done_q;
  logic [SW-1:0] sum_q;

  // Residues of k+1, shared by the stepping logic of both builds
  logic [1:0] m3_inc;
  logic [2:0] m5_inc;
  assign m3_inc = (m3_q == 2'd2) ? 2'd0 : m3_q + 2'd1;
  assign m5_inc = (m5_q == 3'd4) ? 3'd0 : m5_q + 3'd1;

`ifdef MULT35_WHEEL_EN
  // k mod 15 from (k mod 3, k mod 5): 10 == 1 mod 3 / 0 mod 5, 6 == 0 mod 3 / 1 mod 5
  function automatic logic [3:0] wheel_idx(input logic [1:0] r3, input logic [2:0] r5);
    logic [5:0] t;
    t = 6'(r3) * 6'd10 + 6'(r5) * 6'd6;
    if (t >= 6'd30)      t = t - 6'd30;
    else if (t >= 6'd15) t = t - 6'd15;
    return t[3:0];
  endfunction

  // Distance from residue r to the nearest multiple of 3 or 5 at or above it
  function automatic logic [1:0] wheel_dist(input logic [3:0] r);
    case (r)
      4'd1, 4'd7, 4'd13:                 wheel_dist = 2'd2;
      4'd2, 4'd4, 4'd8, 4'd11, 4'd14:    wheel_dist = 2'd1;
      default:                           wheel_dist = 2'd0;
    endcase
  endfunction

  logic [W:0] base_k, nk;
  logic [1:0] base_m3, nm3, dist;
  logic [2:0] base_m5, nm5, t3, t5;

  // Next multiple: searched from k in SCAN, from k+1 after a HOLD handshake.
  // nk is one bit wider so k+2 near 2^W cannot wrap below Nreg.
  always_comb begin
    if (state_q == HOLD) begin
      base_k  = {1'b0, k_q} + 1'b1;
      base_m3 = m3_inc;
      base_m5 = m5_inc;
    end else begin
      base_k  = {1'b0, k_q};
      base_m3 = m3_q;
      base_m5 = m5_q;
    end
    dist = wheel_dist(wheel_idx(base_m3, base_m5));
    nk   = base_k + (W+1)'(dist);
    t3   = {1'b0, base_m3} + {1'b0, dist};
    t5   = base_m5 + {1'b0, dist};
    nm3  = (t3 >= 3'd3) ? 2'(t3 - 3'd3) : t3[1:0];
    nm5  = (t5 >= 3'd5) ? (t5 - 3'd5) : t5;
  end
`endif

  // Control FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      m3_q    <= '0;
      m5_q    <= '0;
      out_q   <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.st) begin
            n_q     <= bus.in;
            k_q     <= W'(1);
            m3_q    <= 2'd1;
            m5_q    <= 3'd1;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
`ifdef MULT35_WHEEL_EN
        SCAN, HOLD: begin
          if (state_q == SCAN || (valid_q && bus.ready)) begin
            if (nk >= {1'b0, n_q}) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              k_q     <= nk[W-1:0];
              m3_q    <= nm3;
              m5_q    <= nm5;
              out_q   <= nk[W-1:0];
              tag_q   <= {nm5 == 3'd0, nm3 == 2'd0};
              valid_q <= 1'b1;
              sum_q   <= sum_q + SW'(nk[W-1:0]);
              state_q <= HOLD;
            end
          end
        end
`else
        SCAN: begin
          if (k_q >= n_q) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end else if (m3_q == 2'd0 || m5_q == 3'd0) begin
            out_q   <= k_q;
            tag_q   <= {m5_q == 3'd0, m3_q == 2'd0};
            valid_q <= 1'b1;
            sum_q   <= sum_q + SW'(k_q);
            state_q <= HOLD;
          end else begin
            k_q  <= k_q + 1'b1;
            m3_q <= m3_inc;
            m5_q <= m5_inc;
          end
        end
        HOLD: begin
          if (valid_q && bus.ready) begin
            valid_q <= 1'b0;
            k_q     <= k_q + 1'b1;
            m3_q    <= m3_inc;
            m5_q    <= m5_inc;
            state_q <= SCAN;
          end
        end
`endif
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.out   = out_q;
  assign bus.tag   = tag_q;
  assign bus.valid = valid_q;
  assign bus.sum   = sum_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_mult35_stream.sv
// Bench for mult35_stream: table of sequences plus random N, each checked
// against a list of expected terms built with plain % arithmetic.
module tb_mult35_stream;
  localparam int W  = 16;
  localparam int SW = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mult35_if #(.W(W), .SW(SW)) bus ();
  mult35_stream #(.W(W), .SW(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int n;
    bit rnd;
    bit inject;
    int exp_beats;
    int exp_sum;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Runs one sequence from IDLE; returns beat count. Called at a negedge.
  task automatic run_seq(input int n, input bit rnd, input bit inject, output int nbeats);
    int  exp_q[$];
    int  got_q[$];
    int  gtag_q[$];
    int  sumexp, cyc, dones, first_c, last_c, lim, m;
    bit  fin, prev_stall, rdy;
    logic [W-1:0] pout;
    logic [1:0]   ptag;
    sumexp = 0;
    for (int k = 1; k < n; k++)
      if (k % 3 == 0 || k % 5 == 0) begin
        exp_q.push_back(k);
        sumexp += k;
      end
    bus.in = W'(n); bus.st = 1'b1; bus.ready = 1'b0;
    @(negedge clk);
    bus.st = 1'b0; bus.in = '0;
    chk("busy_after_st", bus.busy, 1);
    cyc = 0; dones = 0; fin = 0; prev_stall = 0; first_c = -1; last_c = -1;
    pout = '0; ptag = '0;
    lim = 10 * n + 100;
    while (!fin && cyc < lim) begin
      if (prev_stall) begin
        chk("stall_valid", bus.valid, 1);
        chk("stall_out", bus.out, pout);
        chk("stall_tag", bus.tag, ptag);
      end
      if (bus.done) begin
        dones++;
        fin = 1;
        chk("busy_during_done", bus.busy, 1);
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.ready = rdy;
      if (bus.valid && rdy) begin
        got_q.push_back(int'(bus.out));
        gtag_q.push_back(int'(bus.tag));
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
      prev_stall = bus.valid && !rdy;
      pout = bus.out; ptag = bus.tag;
      if (inject && cyc == 5) begin bus.st = 1'b1; bus.in = W'(50); end
      else begin bus.st = 1'b0; bus.in = '0; end
      @(negedge clk);
      cyc++;
    end
    bus.st = 1'b0; bus.ready = 1'b0;
    chk("done_seen", fin, 1);
    chk("done_pulses", dones, 1);
    chk("done_one_cycle", bus.done, 0);
    chk("busy_after_done", bus.busy, 0);
    chk("valid_after_done", bus.valid, 0);
    chk("sum", bus.sum, sumexp);
    chk("beat_count", got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk("beat_out", got_q[i], exp_q[i]);
      chk("beat_tag", gtag_q[i], ((exp_q[i] % 5 == 0) ? 2 : 0) + ((exp_q[i] % 3 == 0) ? 1 : 0));
    end
`ifdef MULT35_WHEEL_EN
    if (!rnd && got_q.size() > 0) chk("wheel_back_to_back", last_c - first_c, got_q.size() - 1);
`endif
    nbeats = got_q.size();
  endtask

  initial begin
    vec_t tbl[6];
    int   nb, n, w;
    tbl[0] = '{n: 10,   rnd: 0, inject: 0, exp_beats: 4,   exp_sum: 23};
    tbl[1] = '{n: 16,   rnd: 0, inject: 0, exp_beats: 7,   exp_sum: 60};
    tbl[2] = '{n: 3,    rnd: 0, inject: 0, exp_beats: 0,   exp_sum: 0};
    tbl[3] = '{n: 0,    rnd: 0, inject: 0, exp_beats: 0,   exp_sum: 0};
    tbl[4] = '{n: 1000, rnd: 1, inject: 0, exp_beats: 466, exp_sum: 233168};
    tbl[5] = '{n: 20,   rnd: 0, inject: 1, exp_beats: 8,   exp_sum: 78};

    rst_n = 1'b0; bus.in = '0; bus.st = 1'b0; bus.ready = 1'b0;
    #1;
    chk("rst_valid", bus.valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out", bus.out, 0);
    chk("rst_tag", bus.tag, 0);
    chk("rst_sum", bus.sum, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_seq(tbl[i].n, tbl[i].rnd, tbl[i].inject, nb);
      chk("tbl_beats", nb, tbl[i].exp_beats);
      chk("tbl_sum", bus.sum, tbl[i].exp_sum);
      @(negedge clk);
    end

    // Random bounds with random back-pressure
    for (int i = 0; i < 5; i++) begin
      n = $urandom_range(0, 200);
      run_seq(n, 1'b1, 1'b0, nb);
      @(negedge clk);
    end

    // Reset while holding a beat
    bus.in = W'(100); bus.st = 1'b1; bus.ready = 1'b0;
    @(negedge clk);
    bus.st = 1'b0;
    w = 0;
    while (!bus.valid && w < 20) begin @(negedge clk); w++; end
    chk("hold_reached", bus.valid, 1);
    chk("hold_first_out", bus.out, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_sum", bus.sum, 0);
    chk("midrst_out", bus.out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_busy", bus.busy, 0);
    chk("post_rst_idle_valid", bus.valid, 0);
    run_seq(10, 1'b0, 1'b0, nb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
